// File: rtl/rr_mux_reg.sv
// Purpose : N-channel round-robin arbiter feeding a single one-slot output register.
// Latency : 1 cycle; a word accepted at edge t is on out_* right after edge t.
// Backpr. : in_ready is withheld while out_valid & !out_ready. Drain and refill can happen in one cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset; clears the output slot and the priority pointer
//   in_data    N_CH*WIDTH packed words, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel request
//   in_ready   one-hot (or zero) grant; high while the channel's word is consumed this cycle
//   out_data   registered selected word
//   out_chan   registered index of the channel that supplied out_data
//   out_valid  output slot holds a word
//   out_ready  consumer takes the word this cycle
//
// Build option: define RR_MUX_REG_FIXED_PRI_EN to replace round-robin with fixed
// priority (lowest index wins). In that build the pointer register does not exist.

module rr_mux_reg #(
  parameter int N_CH  = 8,
  parameter int WIDTH = 8,
  localparam int CW   = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [CW-1:0]         out_chan,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // The output slot is either EMPTY or FULL; out_valid is a direct decode of it.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              load;
  logic              any_req;
  logic              accept;
  logic              found;
  int                idx;
  logic [CW-1:0]     start_idx;
  logic [CW-1:0]     grant;
  logic [N_CH-1:0]   grant_oh;
  logic [WIDTH-1:0]  sel_data;

  // ---------------------------------------------------------------------------
  // Search start point
  // ---------------------------------------------------------------------------
`ifdef RR_MUX_REG_FIXED_PRI_EN
  assign start_idx = '0;
`else
  logic [CW-1:0] ptr;
  logic [CW-1:0] ptr_nxt;

  assign start_idx = ptr;

  // The channel after the winner gets first look next time; explicit wrap
  // keeps the pointer inside 0..N_CH-1 when N_CH is not a power of two.
  assign ptr_nxt = (grant == CW'(N_CH - 1)) ? '0 : grant + CW'(1);
`endif

  // ---------------------------------------------------------------------------
  // Grant search: first set in_valid bit at or after start_idx, wrapping at N_CH.
  // ---------------------------------------------------------------------------
  always_comb begin
    found    = 1'b0;
    idx      = 0;
    grant    = '0;
    grant_oh = '0;
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(start_idx) + i;
      if (idx >= N_CH) begin
        idx = idx - N_CH;
      end
      if (!found && in_valid[idx]) begin
        found         = 1'b1;
        grant         = CW'(idx);
        grant_oh[idx] = 1'b1;
        sel_data      = in_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  assign any_req   = |in_valid;
  assign out_valid = (state == FULL);
  assign load      = !out_valid || out_ready;

  // Reset gating keeps in_ready low while reset is held even though the empty
  // slot would otherwise make load true.
  assign accept    = load && any_req && !reset;
  assign in_ready  = accept ? grant_oh : '0;

  // ---------------------------------------------------------------------------
  // Output slot state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        // A refill in the same cycle as the drain keeps the slot full.
        if (out_ready && !accept) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Data path: loads only on accept, so data/chan hold across drains and stalls.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data <= '0;
      out_chan <= '0;
    end else if (accept) begin
      out_data <= sel_data;
      out_chan <= grant;
    end
  end

`ifndef RR_MUX_REG_FIXED_PRI_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= ptr_nxt;
    end
  end
`endif

endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
- Parametrised, registered N-channel multiplexer; sequential successor to the combinational mux2/mux4/mux8 cells.
- Arbitrates among N_CH valid/ready input channels using round-robin priority.
- Forwards one WIDTH-bit word per handshake to a single registered output port, tagged with the source channel index.
- Used wherever several producers share one downstream consumer.

Parameters:
- N_CH, 8, number of input channels; legal range 2..16.
- WIDTH, 8, data bits per channel.
- CW, $clog2(N_CH), width of the channel index; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  N_CH  channel k has a word available.
- in_ready  output  N_CH  one-hot or zero; channel k's word is consumed this cycle.
- out_data  output  WIDTH  registered selected word.
- out_chan  output  CW  registered index of the channel that supplied out_data.
- out_valid  output  1  out_data/out_chan hold a word.
- out_ready  input  1  consumer accepts the word this cycle.

Behaviour:
- Reset (asynchronous, active-high, any time including mid-transfer):
  - out_valid=0, out_data=0, out_chan=0, priority pointer ptr=0.
  - in_ready=0 while reset is asserted.
  - Any held word is discarded.
- Output register has one slot. Two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load = !out_valid | out_ready. Full throughput: one word per cycle when the consumer is always ready.
- Grant selection (combinational):
  - Search in_valid starting at index ptr, ascending, wrapping N_CH-1 -> 0.
  - The first set bit is grant g; any_req = |in_valid.
- in_ready[g] = load & any_req; all other in_ready bits = 0. in_ready never depends on in_ready itself; it may depend on in_valid and out_ready.
- Accept (load & any_req at the rising edge):
  - out_data <= in_data[g]; out_chan <= g; out_valid <= 1.
  - ptr <= (g==N_CH-1) ? 0 : g+1.
- Drain without refill (out_valid & out_ready & !any_req): out_valid <= 0. out_data and out_chan hold their last values.
- Stall (out_valid & !out_ready):
  - out_data, out_chan, out_valid and ptr hold.
  - in_ready = 0.
- Latency: a word accepted at edge t is visible on out_* right after edge t (one-cycle registered latency).
- Simultaneous drain and refill in one cycle is legal and yields back-to-back words with out_valid held at 1.
- ptr changes only on accept; it does not change while idle or stalled.
- Fairness: with all channels continuously valid and out_ready=1, the grant order is 0,1,...,N_CH-1,0,...
- A channel dropping in_valid before it is granted is legal; the arbiter simply skips it.
- N_CH not a power of two: indices >= N_CH never appear on out_chan, and ptr wraps at N_CH.

Optional Feature:
- Macro: RR_MUX_REG_FIXED_PRI_EN.
- Defined: the pointer is ignored; the search always starts at index 0, so the lowest-numbered valid channel wins. The ptr register is not instantiated.
- Undefined (default): round-robin as described above.
- All other timing and handshake behaviour is identical in both builds.

Test Plan:
- Reset check: assert reset asynchronously mid-cycle while out_valid=1 -> out_valid, out_data and out_chan read 0 immediately; in_ready=0 while reset is high.
- Round-robin order: N_CH=8, WIDTH=8, in_data[k]=8'hA0+k, all in_valid=1, out_ready=1 for 10 cycles -> out_chan sequence 0..7,0,1; out_data A0..A7,A0,A1; exactly one in_ready bit high each cycle.
- Backpressure: out_ready=0 for 4 cycles while word 8'hA3 is held -> out_data=A3 and out_chan=3 stable, in_ready=0; on the first cycle out_ready=1 -> A3 drains and A4 loads in the same cycle, with out_valid held at 1.
- Sparse requests and wrap: only in_valid[6] and in_valid[1], ptr=7 -> grant 1 then 6; next grant with only ch1 valid is 1.
- Drain to empty: single in_valid[2] pulse with data 8'h5C, out_ready=1 -> one cycle with out_valid=1, out_data=5C, out_chan=2; then out_valid=0 and ptr=3.
- Fixed-priority build: with RR_MUX_REG_FIXED_PRI_EN defined, channels 0 and 5 continuously valid -> out_chan=0 every cycle and channel 5 is never granted.
